fpu_issue: RTL and testbench
============================

Name: fpu_issue

Overview:
- Requester-side sequencer for the single-precision FPU's en/valid/idle unit protocol.
- Accepts FP requests from the CPU execute stage over a valid/ready handshake and resolves sign-only ops (FNEG, FABS) locally.
- Drives add/sub ops into one pipelined adder unit and returns each result with its destination tag on a valid/ready response channel.
- Sits between the execute stage and the adder instance inside the FPU top; the adder is instantiated outside this block.

Parameters:
- TAG_W, 5, width of destination-register tag carried with each request.
- TIMEOUT_CYCLES, 8, WAIT-state cycles allowed before declaring the unit hung.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in S_IDLE.
- req_op  in  2  operation: 0 ADD, 1 SUB, 2 NEG, 3 ABS.
- req_tag  in  TAG_W  destination tag.
- req_x1  in  32  operand 1, IEEE-754 single.
- req_x2  in  32  operand 2; ignored for NEG/ABS.
- resp_valid  out  1  result present.
- resp_ready  in  1  consumer takes the result.
- resp_y  out  32  result.
- resp_tag  out  TAG_W  tag of the result.
- err_timeout  out  1  sticky: the unit failed to complete.
- fu_en  out  1  start pulse to the adder.
- fu_x1  out  32  adder operand 1.
- fu_x2  out  32  adder operand 2.
- fu_y  in  32  adder result.
- fu_valid  in  1  adder result valid (level, not a pulse).
- fu_idle  in  1  adder ready to sample en.

Behaviour:
- Reset values: state S_IDLE; resp_valid=0; resp_y=0; resp_tag=0; fu_x1=0; fu_x2=0; err_timeout=0; wait counter=0.
- Reset is asynchronous and may arrive mid-operation.
- fu_en is combinational: high only when state==S_ISSUE and fu_idle==1.
- req_ready is combinational: equals (state==S_IDLE).

State S_IDLE, on req_valid && req_ready:
- Latch tag into resp_tag.
- ADD: fu_x1=x1, fu_x2=x2; go to S_ISSUE.
- SUB: fu_x1=x1, fu_x2={~x2[31], x2[30:0]}; go to S_ISSUE.
- NEG: resp_y={~x1[31], x1[30:0]}; go to S_RESP.
- ABS: resp_y={1'b0, x1[30:0]}; go to S_RESP.
- NaN/denormal payloads pass through bitwise; no canonicalisation.

State S_ISSUE:
- Hold until fu_idle==1; fu_en is high during that cycle; then go to S_WAIT and clear the counter.
- fu_x1 and fu_x2 stay stable from S_ISSUE through S_WAIT.

State S_WAIT:
- fu_valid is a level signal and may still be high from a previous op. Completion is therefore fu_idle && fu_valid, which can only occur after the unit has dropped idle for this op.
- On completion: resp_y=fu_y; go to S_RESP.
- Otherwise increment the counter. When it reaches TIMEOUT_CYCLES: err_timeout=1 (sticky until rst), resp_y=32'h7FC00000; go to S_RESP.

State S_RESP:
- resp_valid=1 (registered).
- resp_y and resp_tag are held stable until resp_ready.
- On resp_ready: resp_valid=0 and go to S_IDLE.

Latency, counting the accept edge as cycle 0:
- ADD/SUB: fu_en in cycle 1; fu_idle low in cycles 2–3; fu_valid/fu_idle high in cycle 4; resp_valid in cycle 5.
- NEG/ABS: resp_valid in cycle 1.
- Best-case ADD throughput is one per 6 cycles, since req_ready is low outside S_IDLE.

Simultaneous events:
- A response handshake and a new request cannot overlap, because req_ready=0 in S_RESP.
- rst has priority over all transitions.

Reset mid-operation:
- The adder has no reset and may still be busy. The issuer returns to S_IDLE.
- A later ADD waits in S_ISSUE for fu_idle.
- The stale result is never delivered, because completion is only checked after this block's own fu_en.

Decomposition:
- Package fpu_pkg: typedef enum logic [1:0] fpu_op_t {FOP_ADD, FOP_SUB, FOP_NEG, FOP_ABS}; constant FP_QNAN=32'h7FC00000.
- State enum {S_IDLE, S_ISSUE, S_WAIT, S_RESP} is local to the module.
- No sub-module: the sign ops are three bit-assigns. The adder is wired to this block in the FPU top.

Test Plan:
- ADD 3F800000 + 40000000, tag 7, real adder attached -> resp_y=40400000, resp_tag=7, resp_valid exactly 5 cycles after accept.
- SUB 3F800000 - 3F800000 -> fu_x2=BF800000 during S_ISSUE; resp_y=00000000.
- NEG 40400000, tag 3 -> resp_y=C0400000 one cycle after accept; fu_en never asserted. ABS C0400000 -> 40400000.
- Two back-to-back ADDs, second with fu_valid still high from the first -> second result is correct, not the first result repeated. Hold resp_ready low for 10 cycles -> resp_y/resp_tag/resp_valid stable and req_ready=0 throughout.
- Stub adder holds fu_idle=0 -> err_timeout=1 after 8 S_WAIT cycles; resp_y=7FC00000; err_timeout stays 1 across later requests until rst.
- rst pulsed in S_WAIT -> all outputs return to reset values immediately; next ADD 40400000 + 3F800000 returns 40800000; no extra response is emitted.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU issue path.
package fpu_pkg;

   localparam int unsigned FP_W = 32;

   typedef enum logic [1:0] {
      FOP_ADD = 2'd0,
      FOP_SUB = 2'd1,
      FOP_NEG = 2'd2,
      FOP_ABS = 2'd3
   } fpu_op_t;

   localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

   // Sign-only ops are bitwise: NaN and denormal payloads pass through untouched.
   function automatic logic [FP_W-1:0] fp_flip_sign(input logic [FP_W-1:0] x);
      return {~x[FP_W-1], x[FP_W-2:0]};
   endfunction

   function automatic logic [FP_W-1:0] fp_clear_sign(input logic [FP_W-1:0] x);
      return {1'b0, x[FP_W-2:0]};
   endfunction

endpackage

// File: rtl/fpu_issue_if.sv
// Request/response channels between the execute stage and the FPU issuer.
interface fpu_issue_if #(
   parameter int unsigned TAG_W = 5
);
   import fpu_pkg::*;

   logic                req_valid;
   logic                req_ready;
   fpu_op_t             req_op;
   logic [TAG_W-1:0]    req_tag;
   logic [FP_W-1:0]     req_x1;
   logic [FP_W-1:0]     req_x2;

   logic                resp_valid;
   logic                resp_ready;
   logic [FP_W-1:0]     resp_y;
   logic [TAG_W-1:0]    resp_tag;

   modport master (
      output req_valid, req_op, req_tag, req_x1, req_x2, resp_ready,
      input  req_ready, resp_valid, resp_y, resp_tag
   );

   modport slave (
      input  req_valid, req_op, req_tag, req_x1, req_x2, resp_ready,
      output req_ready, resp_valid, resp_y, resp_tag
   );

endinterface

// File: rtl/fpu_issue.sv
// Requester-side sequencer: resolves sign ops locally and drives add/sub ops
// through one external pipelined adder using its en/valid/idle protocol.
module fpu_issue
   import fpu_pkg::*;
#(
   parameter int unsigned TAG_W          = 5,
   parameter int unsigned TIMEOUT_CYCLES = 8
) (
   input  logic             clk,
   input  logic             rst,
   fpu_issue_if.slave       req_if,
   output logic             err_timeout,
   output logic             fu_en,
   output logic [FP_W-1:0]  fu_x1,
   output logic [FP_W-1:0]  fu_x2,
   input  logic [FP_W-1:0]  fu_y,
   input  logic             fu_valid,
   input  logic             fu_idle
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t            state_q, state_d;
   logic              resp_valid_q, resp_valid_d;
   logic [FP_W-1:0]   resp_y_q, resp_y_d;
   logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
   logic [FP_W-1:0]   fu_x1_q, fu_x1_d;
   logic [FP_W-1:0]   fu_x2_q, fu_x2_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;

   assign cnt_inc = cnt_q + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         resp_valid_q <= 1'b0;
         resp_y_q     <= '0;
         resp_tag_q   <= '0;
         fu_x1_q      <= '0;
         fu_x2_q      <= '0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= resp_valid_d;
         resp_y_q     <= resp_y_d;
         resp_tag_q   <= resp_tag_d;
         fu_x1_q      <= fu_x1_d;
         fu_x2_q      <= fu_x2_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      resp_valid_d = resp_valid_q;
      resp_y_d     = resp_y_q;
      resp_tag_d   = resp_tag_q;
      fu_x1_d      = fu_x1_q;
      fu_x2_d      = fu_x2_q;
      err_d        = err_q;
      cnt_d        = cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (req_if.req_valid) begin
               resp_tag_d = req_if.req_tag;
               unique case (req_if.req_op)
                  FOP_ADD: begin
                     fu_x1_d = req_if.req_x1;
                     fu_x2_d = req_if.req_x2;
                     state_d = S_ISSUE;
                  end
                  FOP_SUB: begin
                     fu_x1_d = req_if.req_x1;
                     fu_x2_d = fp_flip_sign(req_if.req_x2);
                     state_d = S_ISSUE;
                  end
                  FOP_NEG: begin
                     resp_y_d     = fp_flip_sign(req_if.req_x1);
                     resp_valid_d = 1'b1;
                     state_d      = S_RESP;
                  end
                  FOP_ABS: begin
                     resp_y_d     = fp_clear_sign(req_if.req_x1);
                     resp_valid_d = 1'b1;
                     state_d      = S_RESP;
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_ISSUE: begin
            if (fu_idle) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // fu_valid is a level that may linger from an older op; idle must come back too.
            if (fu_idle && fu_valid) begin
               resp_y_d     = fu_y;
               resp_valid_d = 1'b1;
               state_d      = S_RESP;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                  err_d        = 1'b1;
                  resp_y_d     = FP_QNAN;
                  resp_valid_d = 1'b1;
                  state_d      = S_RESP;
               end
            end
         end
         S_RESP: begin
            if (req_if.resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign fu_en             = (state_q == S_ISSUE) && fu_idle;
   assign req_if.req_ready  = (state_q == S_IDLE);
   assign req_if.resp_valid = resp_valid_q;
   assign req_if.resp_y     = resp_y_q;
   assign req_if.resp_tag   = resp_tag_q;
   assign fu_x1             = fu_x1_q;
   assign fu_x2             = fu_x2_q;
   assign err_timeout       = err_q;

endmodule

// File: tb/tb_fpu_issue.sv
// Directed bench for fpu_issue with a behavioural single-precision adder attached.
module tb_fpu_issue;
   import fpu_pkg::*;

   localparam int unsigned TAG_W = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        err_timeout;
   logic        fu_en;
   logic [31:0] fu_x1, fu_x2;
   logic [31:0] fu_y     = 32'h0;
   logic        fu_valid = 1'b0;
   logic        fu_idle  = 1'b1;

   int          checks = 0;
   int          errors = 0;

   // Adder model state
   int          busy  = 0;
   logic [31:0] res_m = 32'h0;
   bit          hang  = 1'b0;

   fpu_issue_if #(.TAG_W(TAG_W)) bus ();

   fpu_issue #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_if      (bus),
      .err_timeout (err_timeout),
      .fu_en       (fu_en),
      .fu_x1       (fu_x1),
      .fu_x2       (fu_x2),
      .fu_y        (fu_y),
      .fu_valid    (fu_valid),
      .fu_idle     (fu_idle)
   );

   always #5 clk = ~clk;

   // Truncating fp32 add, sufficient for the normal-number vectors used here.
   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] big, sml;
      logic [7:0]  e, d;
      logic [24:0] mb, ms, m;
      if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
      else begin big = b; sml = a; end
      e  = big[30:23];
      mb = {1'b0, big[30:23] != 8'd0, big[22:0]};
      ms = {1'b0, sml[30:23] != 8'd0, sml[22:0]};
      d  = big[30:23] - sml[30:23];
      ms = (d > 8'd24) ? 25'd0 : (ms >> d);
      if (big[31] == sml[31]) begin
         m = mb + ms;
         if (m[24]) begin m = m >> 1; e = e + 8'd1; end
      end else begin
         m = mb - ms;
         if (m == 25'd0) return 32'h0;
         for (int i = 0; i < 24; i++)
            if (!m[23]) begin m = m << 1; e = e - 8'd1; end
      end
      return {big[31], e, m[22:0]};
   endfunction

   // Adder: samples en, drops idle two cycles, then raises idle and a sticky valid level.
   always @(posedge clk) begin
      if (fu_en) begin
         fu_idle <= 1'b0;
         busy    <= 2;
         res_m   <= fp_add(fu_x1, fu_x2);
      end else if (busy == 2) begin
         busy <= 1;
      end else if (busy == 1 && !hang) begin
         busy     <= 0;
         fu_idle  <= 1'b1;
         fu_valid <= 1'b1;
         fu_y     <= res_m;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one request; returns at the falling edge of cycle 1 after the accept edge.
   task automatic send(input fpu_op_t op, input logic [4:0] tag,
                       input logic [31:0] x1, input logic [31:0] x2);
      int n = 0;
      while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
      check("req_ready_before_send", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_tag   = tag;
      bus.req_x1    = x1;
      bus.req_x2    = x2;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   // Count cycles until resp_valid, tallying fu_en pulses and the operands seen with them.
   task automatic wait_resp(output int lat, output int en_cnt,
                            output logic [31:0] x1_seen, output logic [31:0] x2_seen);
      lat = 1; en_cnt = 0; x1_seen = 32'hx; x2_seen = 32'hx;
      forever begin
         if (fu_en) begin en_cnt++; x1_seen = fu_x1; x2_seen = fu_x2; end
         if (bus.resp_valid || lat >= 40) break;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic take(input string tag, input logic [31:0] y, input logic [4:0] t);
      check({tag, "_valid"}, 64'(bus.resp_valid), 64'd1);
      check({tag, "_y"},     64'(bus.resp_y),     64'(y));
      check({tag, "_tag"},   64'(bus.resp_tag),   64'(t));
      bus.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.resp_ready = 1'b0;
      check({tag, "_drop"},  64'({bus.resp_valid, bus.req_ready}), 64'b01);
   endtask

   initial begin
      int          lat, en_cnt, seen;
      logic [31:0] x1s, x2s;

      bus.req_valid  = 1'b0;
      bus.req_op     = FOP_ADD;
      bus.req_tag    = '0;
      bus.req_x1     = '0;
      bus.req_x2     = '0;
      bus.resp_ready = 1'b0;

      // Reset values
      @(negedge clk);
      check("rst_outputs", 64'({bus.resp_valid, bus.resp_y, bus.resp_tag, err_timeout, fu_en}), 64'd0);
      check("rst_fu_x", 64'({fu_x1, fu_x2}), 64'd0);
      check("rst_ready", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // ADD 1.0 + 2.0
      send(FOP_ADD, 5'd7, 32'h3F80_0000, 32'h4000_0000);
      wait_resp(lat, en_cnt, x1s, x2s);
      check("add_lat", 64'(lat), 64'd5);
      check("add_en", 64'(en_cnt), 64'd1);
      take("add", 32'h4040_0000, 5'd7);

      // SUB 1.0 - 1.0: adder sees the negated second operand
      send(FOP_SUB, 5'd9, 32'h3F80_0000, 32'h3F80_0000);
      wait_resp(lat, en_cnt, x1s, x2s);
      check("sub_x1", 64'(x1s), 64'h3F80_0000);
      check("sub_x2", 64'(x2s), 64'hBF80_0000);
      check("sub_lat", 64'(lat), 64'd5);
      take("sub", 32'h0000_0000, 5'd9);

      // NEG and ABS resolve locally
      send(FOP_NEG, 5'd3, 32'h4040_0000, 32'h1234_5678);
      wait_resp(lat, en_cnt, x1s, x2s);
      check("neg_lat", 64'(lat), 64'd1);
      check("neg_en", 64'(en_cnt), 64'd0);
      take("neg", 32'hC040_0000, 5'd3);
      send(FOP_ABS, 5'd4, 32'hC040_0000, 32'h0);
      wait_resp(lat, en_cnt, x1s, x2s);
      check("abs_lat", 64'(lat), 64'd1);
      check("abs_en", 64'(en_cnt), 64'd0);
      take("abs", 32'h4040_0000, 5'd4);

      // Back-to-back ADDs with fu_valid still high from the previous op
      send(FOP_ADD, 5'd10, 32'h3F80_0000, 32'h4000_0000);
      wait_resp(lat, en_cnt, x1s, x2s);
      take("b2b_first", 32'h4040_0000, 5'd10);
      check("b2b_stale_valid", 64'(fu_valid), 64'd1);
      send(FOP_ADD, 5'd11, 32'h4000_0000, 32'h4040_0000);
      wait_resp(lat, en_cnt, x1s, x2s);
      check("b2b_lat", 64'(lat), 64'd5);
      for (int i = 0; i < 10; i++) begin
         check("hold_stable", 64'({bus.resp_valid, bus.resp_y, bus.resp_tag, bus.req_ready}),
               64'({1'b1, 32'h40A0_0000, 5'd11, 1'b0}));
         @(negedge clk);
      end
      take("b2b_second", 32'h40A0_0000, 5'd11);

      // Hung adder: timeout after 8 WAIT cycles, sticky error
      hang = 1'b1;
      send(FOP_ADD, 5'd12, 32'h3F80_0000, 32'h4000_0000);
      wait_resp(lat, en_cnt, x1s, x2s);
      check("to_lat", 64'(lat), 64'd10);
      check("to_err", 64'(err_timeout), 64'd1);
      take("to", 32'h7FC0_0000, 5'd12);
      send(FOP_NEG, 5'd13, 32'h3F80_0000, 32'h0);
      wait_resp(lat, en_cnt, x1s, x2s);
      check("to_err_neg", 64'(err_timeout), 64'd1);
      take("to_neg", 32'hBF80_0000, 5'd13);
      hang = 1'b0;
      send(FOP_ADD, 5'd14, 32'h4000_0000, 32'h4040_0000);
      wait_resp(lat, en_cnt, x1s, x2s);
      check("to_err_add", 64'(err_timeout), 64'd1);
      check("to_add_lat", 64'(lat), 64'd5);
      take("to_add", 32'h40A0_0000, 5'd14);

      // Reset in S_WAIT while the adder is busy
      send(FOP_ADD, 5'd15, 32'h3F80_0000, 32'h4000_0000);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_outputs", 64'({bus.resp_valid, bus.resp_y, bus.resp_tag, err_timeout, fu_en}), 64'd0);
      check("mid_rst_fu_x", 64'({fu_x1, fu_x2}), 64'd0);
      check("mid_rst_ready", 64'(bus.req_ready), 64'd1);
      #1;
      rst = 1'b0;
      send(FOP_ADD, 5'd16, 32'h4040_0000, 32'h3F80_0000);
      wait_resp(lat, en_cnt, x1s, x2s);
      check("post_rst_lat", 64'(lat), 64'd6);
      check("post_rst_en", 64'(en_cnt), 64'd1);
      take("post_rst", 32'h4080_0000, 5'd16);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.resp_valid) seen++;
         @(negedge clk);
      end
      check("no_extra_resp", 64'(seen), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
